// File: rtl/uart_buffered_pkg.sv
// Shared types and constants for the buffered 8N1 UART.
package uart_buffered_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO feeding the UART serialiser; read data is registered on the read edge.
module uart_byte_fifo
    import uart_buffered_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_W-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 wr_en;
    logic                 rd_en;
    logic [CNT_W-1:0]     count_next;

    // A write at full is still accepted when a read frees the slot in the same cycle.
    always_comb begin
        rd_en      = rd & ~empty;
        wr_en      = wr & (~full | rd_en);
        count_next = count;
        if (wr_en && !rd_en)
            count_next = count + CNT_W'(1);
        else if (rd_en && !wr_en)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_buffered.sv
// 8N1 UART with transmit FIFO and drain logic; UART_LOOPBACK_EN adds a
// loopback input that feeds the receiver from the internal tx line.
module uart_buffered
    import uart_buffered_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic [CNT_W-1:0]     tx_count,
    output logic                 tx_busy,
    output logic                 tx,
`ifdef UART_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_error,
    output logic                 rx_busy
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic                 rd;
    logic                 rd_z;
    logic [DATA_BITS-1:0] fifo_out;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (rd),
        .rd_data (fifo_out),
        .full    (tx_full),
        .empty   (tx_empty),
        .count   (tx_count)
    );

    // rd_z blocks a second pop while the popped byte is still on its way into the serialiser.
    assign rd = ~tx_empty & ~tx_busy & ~rd_z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_z <= 1'b0;
        else
            rd_z <= rd;
    end

    uart_state_t          tx_state, tx_state_next;
    logic [DIV_W-1:0]     tx_cnt, tx_cnt_next;
    logic [BIT_W-1:0]     tx_bit, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shreg, tx_shreg_next;
    logic                 tx_next;
    logic                 tx_busy_next;
    logic                 tx_bit_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shreg <= tx_shreg_next;
            tx       <= tx_next;
            tx_busy  <= tx_busy_next;
        end
    end

    // Serialiser: rd_z is the transmit strobe that loads fifo_out.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_shreg_next = tx_shreg;
        tx_next       = tx;
        tx_busy_next  = tx_busy;
        tx_bit_done   = (tx_cnt == DIV_W'(CLK_DIV - 1));
        if (tx_state != IDLE)
            tx_cnt_next = tx_bit_done ? '0 : tx_cnt + DIV_W'(1);
        case (tx_state)
            IDLE: begin
                if (rd_z) begin
                    tx_state_next = START;
                    tx_cnt_next   = '0;
                    tx_shreg_next = fifo_out;
                    tx_next       = START_BIT;
                    tx_busy_next  = 1'b1;
                end
            end
            START: begin
                if (tx_bit_done) begin
                    tx_state_next = DATA;
                    tx_bit_next   = '0;
                    tx_next       = tx_shreg[0];
                end
            end
            DATA: begin
                if (tx_bit_done) begin
                    if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
                        tx_state_next = STOP;
                        tx_next       = STOP_BIT;
                    end else begin
                        tx_bit_next   = tx_bit + BIT_W'(1);
                        tx_shreg_next = tx_shreg >> 1;
                        tx_next       = tx_shreg[1];
                    end
                end
            end
            STOP: begin
                if (tx_bit_done) begin
                    tx_state_next = IDLE;
                    tx_next       = 1'b1;
                    tx_busy_next  = 1'b0;
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    logic rx_src;
    logic rx_s1, rx_s2, rx_prev;

`ifdef UART_LOOPBACK_EN
    assign rx_src = loopback ? tx : rx;
`else
    assign rx_src = rx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_src;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    uart_state_t          rx_state, rx_state_next;
    logic [DIV_W-1:0]     rx_cnt, rx_cnt_next;
    logic [BIT_W-1:0]     rx_bit, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shreg, rx_shreg_next;
    logic [DATA_BITS-1:0] rx_data_next;
    logic                 rx_valid_next;
    logic                 rx_error_next;
    logic                 rx_busy_next;
    logic                 rx_full_bit;
    logic                 rx_half_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_bit   <= rx_bit_next;
            rx_shreg <= rx_shreg_next;
            rx_data  <= rx_data_next;
            rx_valid <= rx_valid_next;
            rx_error <= rx_error_next;
            rx_busy  <= rx_busy_next;
        end
    end

    // Deserialiser: half a bit to the start-bit centre, then one bit period per sample.
    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt + DIV_W'(1);
        rx_bit_next   = rx_bit;
        rx_shreg_next = rx_shreg;
        rx_data_next  = rx_data;
        rx_valid_next = 1'b0;
        rx_error_next = 1'b0;
        rx_full_bit   = (rx_cnt == DIV_W'(CLK_DIV - 1));
        rx_half_bit   = (rx_cnt == DIV_W'(CLK_DIV / 2 - 1));
        case (rx_state)
            IDLE: begin
                rx_cnt_next = '0;
                if (rx_prev && !rx_s2)
                    rx_state_next = START;
            end
            START: begin
                if (rx_half_bit) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_full_bit) begin
                    rx_cnt_next   = '0;
                    rx_shreg_next = {rx_s2, rx_shreg[DATA_BITS-1:1]};
                    if (rx_bit == BIT_W'(DATA_BITS - 1))
                        rx_state_next = STOP;
                    else
                        rx_bit_next = rx_bit + BIT_W'(1);
                end
            end
            STOP: begin
                if (rx_full_bit) begin
                    rx_cnt_next   = '0;
                    rx_state_next = IDLE;
                    if (rx_s2 == STOP_BIT) begin
                        rx_data_next  = rx_shreg;
                        rx_valid_next = 1'b1;
                    end else begin
                        rx_error_next = 1'b1;
                    end
                end
            end
            default: rx_state_next = IDLE;
        endcase
        rx_busy_next = (rx_state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_buffered.sv
// Scoreboard bench for uart_buffered (CLK_DIV=4, FIFO_DEPTH=4); define
// UART_LOOPBACK_EN to also exercise the loopback path.
module tb_uart_buffered;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FRAME_CLKS = 10 * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_wr = 1'b0;
    logic             tx_full;
    logic             tx_empty;
    logic [CNT_W-1:0] tx_count;
    logic             tx_busy;
    logic             tx;
    logic             rx = 1'b1;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_error;
    logic             rx_busy;
`ifdef UART_LOOPBACK_EN
    logic             loopback = 1'b0;
`endif

    uart_buffered #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_count (tx_count),
        .tx_busy  (tx_busy),
        .tx       (tx),
`ifdef UART_LOOPBACK_EN
        .loopback (loopback),
`endif
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rx_pulses = 0;
    bit tx_mon_en = 1'b1;

    logic [7:0] tx_q[$];
    logic [8:0] rx_q[$];   // {is_error, expected rx_data}
    int         start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Decode frames on tx at the second negedge of each bit and score them.
    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_mon_en && !rst && tx === 1'b0) begin
                start_q.push_back(cyc);
                @(negedge clk);
                check("tx_start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                check("tx_stop_bit", tx, 1);
                if (tx_q.size() == 0)
                    check("tx_unexpected_frame", 32'(b), 32'h100);
                else
                    check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
            end
        end
    end

    initial begin : rx_monitor
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && (rx_valid || rx_error)) begin
                rx_pulses++;
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_pulse", {rx_valid, rx_error}, 0);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_valid", rx_valid, !e[8]);
                    check("rx_error", rx_error, e[8]);
                    check("rx_data", rx_data, e[7:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_tx_idle(input string tag);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || tx_busy || !tx_empty) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 2000, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin : main
        int n;
        int lows;
        bit seen_busy;
        int p0;

        // Reset release
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_rx_data", rx_data, 0);
        lows = 0;
        p0 = rx_pulses;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_error !== 1'b0)
                lows++;
        end
        check("rst_quiet_100", lows, 0);
        check("rst_no_pulses", rx_pulses - p0, 0);

        // Single byte: write latency and busy length
        tx_data = 8'hA5;
        tx_wr   = 1'b1;
        tx_q.push_back(8'hA5);
        @(negedge clk);             // after E0
        tx_wr = 1'b0;
        check("lat_after_e0", tx, 1);
        @(negedge clk);             // after E1
        check("lat_after_e1", tx, 1);
        @(negedge clk);             // after E2
        check("lat_after_e2", tx, 0);
        n = 0;
        while (tx_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("tx_busy_clocks", n, FRAME_CLKS);
        wait_tx_idle("single_drain");

        // Burst of six writes into a depth-4 FIFO: the first byte is popped one
        // cycle after its write, so DEPTH+1 bytes fit and the sixth is dropped.
        start_q.delete();
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'(i + 1);
            tx_wr   = 1'b1;
            if (i < int'(FIFO_DEPTH) + 1)
                tx_q.push_back(8'(i + 1));
            @(negedge clk);
        end
        tx_wr = 1'b0;
        check("burst_full", tx_full, 1);
        check("burst_count", tx_count, FIFO_DEPTH);
        wait_tx_idle("burst_drain");
        check("burst_frames", start_q.size(), FIFO_DEPTH + 1);
        for (int i = 1; i < start_q.size(); i++)
            check("burst_frame_spacing", start_q[i] - start_q[i-1], FRAME_CLKS + 2);
        check("burst_empty", tx_empty, 1);
        check("burst_count_zero", tx_count, 0);

        // RX good frame
        p0 = rx_pulses;
        rx_q.push_back({1'b0, 8'h3C});
        send_rx(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check("rx_good_pulses", rx_pulses - p0, 1);
        check("rx_good_hold", rx_data, 8'h3C);
        check("rx_good_busy", rx_busy, 0);

        // RX framing error: data must keep the previous byte
        p0 = rx_pulses;
        rx_q.push_back({1'b1, 8'h3C});
        send_rx(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        check("rx_err_pulses", rx_pulses - p0, 1);
        check("rx_err_hold", rx_data, 8'h3C);
        check("rx_err_busy", rx_busy, 0);

        // RX one-clock glitch is a false start
        p0 = rx_pulses;
        seen_busy = 1'b0;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
        end
        check("glitch_started", seen_busy, 1);
        check("glitch_no_pulse", rx_pulses - p0, 0);
        check("glitch_busy_low", rx_busy, 0);

        // Reset in the middle of a 0xFF frame with a second byte queued
        tx_mon_en = 1'b0;
        tx_data = 8'hFF;
        tx_wr   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_wr = 1'b0;
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_started", tx_busy, 1);
        check("rst_mid_pre_tx", tx, 0);
        check("rst_mid_pre_count", tx_count, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_empty", tx_empty, 1);
        check("rst_mid_count", tx_count, 0);
        check("rst_mid_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rst_mid_quiet", lows, 0);
        tx_mon_en = 1'b1;

`ifdef UART_LOOPBACK_EN
        // Loopback: receiver sees the internal tx line
        loopback = 1'b1;
        p0 = rx_pulses;
        tx_q.push_back(8'h81);
        rx_q.push_back({1'b0, 8'h81});
        tx_data = 8'h81;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        wait_tx_idle("loop_drain");
        repeat (10) @(negedge clk);
        check("loop_pulses", rx_pulses - p0, 1);
        check("loop_rx_data", rx_data, 8'h81);
        loopback = 1'b0;
`endif

        repeat (10) @(negedge clk);
        check("tx_queue_drained", tx_q.size(), 0);
        check("rx_queue_drained", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
